// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: datapath width, opcode encodings and the
// return-address offset used by the fetch stage and its return stack.
//   XLEN        - instruction / address width
//   OP_B/CALL/RET - opcodes in instr[15:12]; the only definitions of these codes
//   RET_OFFSET  - CALL return point, skipping the two delay slots
package fetch_stage_pkg;

    localparam int unsigned XLEN = 16;
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_B    = 4'hA;
    localparam logic [OP_W-1:0] OP_CALL = 4'hB;
    localparam logic [OP_W-1:0] OP_RET  = 4'hC;

    localparam logic [XLEN-1:0] RET_OFFSET = 16'd3;

    // Opcode field of an instruction word.
    function automatic logic [OP_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[XLEN-1 -: OP_W];
    endfunction

endpackage

// File: rtl/fetch_stage_ret_stack.sv
// ret_stack: circular return-address stack with write pointer and occupancy.
//   clk, rst_n  - clock, synchronous active-low reset
//   push, pop   - one operation per cycle (never both)
//   push_data   - return address to push
//   top         - most recently pushed entry (undefined when empty)
//   empty       - occupancy is zero
//   err         - registered pulse: push while full or pop while empty
module ret_stack
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full_c;

    assign full_c = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign top    = mem[PTR_W'(wr_ptr - PTR_W'(1))];

    // Entry storage; when full, wr_ptr already points at the oldest entry.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, occupancy and error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            err <= (push && full_c) || (pop && empty);
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
                if (!full_c) begin
                    count <= CNT_W'(count + CNT_W'(1));
                end
            end else if (pop && !empty) begin
                wr_ptr <= PTR_W'(wr_ptr - PTR_W'(1));
                count  <= CNT_W'(count - CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select (RET resolved from the return
// stack), IF/ID pipeline register and stall gating.
//   clk, rst_n       - clock, synchronous active-low reset
//   nxt_pc           - next-PC proposal from jump logic (ignored on RET)
//   ex_pc, ex_instr  - PC and instruction currently in EX
//   ex_valid, stall  - EX holds a real instruction; hold everything
//   imem_rdata       - async instruction memory data for imem_addr
//   imem_addr, if_pc - current fetch PC
//   id_instr, id_pc, id_valid - IF/ID register
//   ras_err          - one-cycle return stack over/underflow pulse
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] nxt_pc,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_instr,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    output logic            ras_err
);

    logic            ex_act_c;
    logic            is_call_c;
    logic            is_ret_c;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic [XLEN-1:0] pc_next_c;

    assign ex_act_c  = ex_valid && !stall;
    assign is_call_c = ex_act_c && (opcode_of(ex_instr) == OP_CALL);
    assign is_ret_c  = ex_act_c && (opcode_of(ex_instr) == OP_RET);

    // RET takes the stack top (zero when empty); nxt_pc is not looked at then.
    always_comb begin
        pc_next_c = nxt_pc;
        if (is_ret_c) begin
            pc_next_c = ras_empty ? '0 : ras_top;
        end
    end

    ret_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ret_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (is_call_c),
        .pop      (is_ret_c),
        .push_data(XLEN'(ex_pc + RET_OFFSET)),
        .top      (ras_top),
        .empty    (ras_empty),
        .err      (ras_err)
    );

    // PC and IF/ID register; reset wins over stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_pc    <= RESET_PC;
            id_instr <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            if_pc    <= pc_next_c;
            id_instr <= imem_rdata;
            id_pc    <= if_pc;
            id_valid <= 1'b1;
        end
    end

    assign imem_addr = if_pc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [3:0] OP_ADD = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] nxt_pc, ex_pc, ex_instr, imem_rdata;
    logic        ex_valid, stall;
    logic [15:0] imem_addr, if_pc, id_instr, id_pc;
    logic        id_valid, ras_err;

    always #5 clk = ~clk;

    // Instruction memory: content derived from the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(16'h0000), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .nxt_pc(nxt_pc), .ex_pc(ex_pc),
        .ex_instr(ex_instr), .ex_valid(ex_valid), .stall(stall),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .if_pc(if_pc),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .ras_err(ras_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (architectural view, return stack as a queue).
    logic [15:0] m_pc, m_id_instr, m_id_pc;
    logic        m_id_valid, m_err;
    logic [15:0] m_ras[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic [3:0] op, input logic [15:0] epc,
                              input logic [15:0] npc);
        logic [15:0] nxt;
        if (!r) begin
            m_pc = 16'h0000; m_id_instr = '0; m_id_pc = '0;
            m_id_valid = 1'b0; m_err = 1'b0; m_ras.delete();
        end else if (s) begin
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            nxt = npc;
            if (v && op == OP_CALL) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back(16'(epc + 16'd3));
            end else if (v && op == OP_RET) begin
                if (m_ras.size() == 0) begin
                    nxt = 16'h0000;
                    m_err = 1'b1;
                end else begin
                    nxt = m_ras.pop_back();
                end
            end
            m_id_instr = mem_word(m_pc);
            m_id_pc    = m_pc;
            m_id_valid = 1'b1;
            m_pc       = nxt;
        end
    endtask

    // One clock: drive at negedge, update model, sample 1 time unit after posedge.
    task automatic step(input logic r, input logic s, input logic v,
                        input logic [3:0] op, input logic [11:0] lo,
                        input logic [15:0] epc, input logic [15:0] npc,
                        input bit npc_x);
        @(negedge clk);
        rst_n = r; stall = s; ex_valid = v; ex_pc = epc;
        ex_instr = {op, lo};
        nxt_pc = npc_x ? 16'hxxxx : npc;
        model_step(r, s, v, op, epc, npc);
        @(posedge clk);
        #1;
        check("if_pc", if_pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("id_instr", id_instr, m_id_instr);
        check("id_pc", id_pc, m_id_pc);
        check("id_valid", 16'(id_valid), 16'(m_id_valid));
        check("ras_err", 16'(ras_err), 16'(m_err));
    endtask

    typedef struct {
        logic        r, s, v;
        logic [3:0]  op;
        logic [15:0] epc, npc;
        bit          npc_x;
        logic [15:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic [3:0] op, input logic [15:0] epc,
                                input logic [15:0] npc, input bit nx,
                                input logic [15:0] ep, input logic ee);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.op = op; t.epc = epc; t.npc = npc;
        t.npc_x = nx; t.exp_pc = ep; t.exp_err = ee;
        return t;
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0;
        ex_pc = '0; ex_instr = '0; nxt_pc = '0;

        // Reset and free run
        vecs.push_back(mk(0, 0, 0, OP_ADD, 16'h0000, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 0, OP_ADD, 16'h0000, 16'h0001, 0, 16'h0001, 0));
        vecs.push_back(mk(1, 0, 0, OP_ADD, 16'h0000, 16'h0002, 0, 16'h0002, 0));
        vecs.push_back(mk(1, 0, 0, OP_ADD, 16'h0000, 16'h0003, 0, 16'h0003, 0));
        vecs.push_back(mk(1, 0, 0, OP_ADD, 16'h0000, 16'h0005, 0, 16'h0005, 0));
        // Stall with a CALL in EX: nothing moves, no push
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 1, 1, OP_CALL, 16'h0050, 16'h0099, 0, 16'h0005, 0));
        // CALL at 0x10, RET with nxt_pc X, then RET underflows (stalled CALL not pushed)
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'h0010, 16'h0020, 0, 16'h0020, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0021, 16'h0000, 1, 16'h0013, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0013, 16'h0000, 1, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 1, OP_ADD,  16'h0000, 16'h0040, 0, 16'h0040, 0));
        // Bubble carrying a RET opcode follows nxt_pc
        vecs.push_back(mk(1, 0, 0, OP_RET,  16'h0041, 16'h0044, 0, 16'h0044, 0));
        // Nested calls
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'h0100, 16'h0500, 0, 16'h0500, 0));
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'h0200, 16'h0600, 0, 16'h0600, 0));
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'h0300, 16'h0700, 0, 16'h0700, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0701, 16'h0000, 1, 16'h0303, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0304, 16'h0000, 1, 16'h0203, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0204, 16'h0000, 1, 16'h0103, 0));
        // Overflow then full drain and underflow
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(1, 0, 1, OP_CALL, 16'(i * 16'h1000), 16'h0800, 0,
                              16'h0800, (i == 5)));
        for (int i = 5; i >= 2; i--)
            vecs.push_back(mk(1, 0, 1, OP_RET, 16'h0801, 16'h0000, 1,
                              16'(i * 16'h1000 + 3), 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h2004, 16'h0000, 1, 16'h0000, 1));
        // Return address wraps modulo 2^16
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'hFFFE, 16'h0900, 0, 16'h0900, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0902, 16'h0000, 1, 16'h0001, 0));
        // Reset during stall with two entries, then RET underflows
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'h00A0, 16'h0030, 0, 16'h0030, 0));
        vecs.push_back(mk(1, 0, 1, OP_CALL, 16'h00B0, 16'h0031, 0, 16'h0031, 0));
        vecs.push_back(mk(0, 1, 1, OP_RET,  16'h0031, 16'h0077, 0, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 1, OP_RET,  16'h0000, 16'h0000, 1, 16'h0000, 1));
        // Error pulse lasts one cycle
        vecs.push_back(mk(1, 0, 0, OP_ADD,  16'h0000, 16'h0123, 0, 16'h0123, 0));

        foreach (vecs[k]) begin
            step(vecs[k].r, vecs[k].s, vecs[k].v, vecs[k].op, 12'h000,
                 vecs[k].epc, vecs[k].npc, vecs[k].npc_x);
            check("vec_pc", if_pc, vecs[k].exp_pc);
            check("vec_err", 16'(ras_err), 16'(vecs[k].exp_err));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic       r, s, v;
            int         sel;
            sel = int'($urandom_range(0, 5));
            op  = (sel < 2) ? OP_CALL : (sel < 4) ? OP_RET : (sel == 4) ? OP_B : OP_ADD;
            r   = ($urandom_range(0, 49) != 0);
            s   = ($urandom_range(0, 3) == 0);
            v   = ($urandom_range(0, 4) != 0);
            step(r, s, v, op, 12'($urandom), 16'($urandom), 16'($urandom),
                 (v && !s && op == OP_RET));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
